// File: rtl/inst_fetch_sequencer_pkg.sv
// Shared fetch definitions: state encoding, fetch geometry and the
// little-endian byte-lane helper (also used by the data-memory load path).
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    VALID = 1'b1
  } fetch_state_e;

  localparam int INST_BYTES = 4;
  localparam int PC_STEP    = 4;

  // Returns word with byte lane 'lane' (bits 8*lane+7 : 8*lane) replaced by data.
  function automatic logic [31:0] le_lane_write(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    result[{lane, 3'b000} +: 8] = data;
    return result;
  endfunction

endpackage

// File: rtl/inst_fetch_sequencer_if.sv
// Bundle of the instruction-memory, decode and redirect signals seen by the
// fetch sequencer. master = sequencer side, slave = memory/decode/execute side.
interface inst_fetch_sequencer_if #(
  parameter int XLEN = 64
);

  logic [XLEN-1:0] Mem_Addr;
  logic            Mem_Rd_En;
  logic [7:0]      Mem_Byte;
  logic [31:0]     Instruction;
  logic            Inst_Valid;
  logic            Inst_Ready;
  logic [XLEN-1:0] Inst_PC;
  logic            Redirect;
  logic [XLEN-1:0] Redirect_PC;

  modport master (
    output Mem_Addr, Mem_Rd_En, Instruction, Inst_Valid, Inst_PC,
    input  Mem_Byte, Inst_Ready, Redirect, Redirect_PC
  );

  modport slave (
    input  Mem_Addr, Mem_Rd_En, Instruction, Inst_Valid, Inst_PC,
    output Mem_Byte, Inst_Ready, Redirect, Redirect_PC
  );

endinterface

// File: rtl/inst_fetch_sequencer.sv
// Instruction fetch sequencer: reads four bytes per instruction from a
// byte-wide memory, assembles them little-endian and offers the word to
// decode over valid/ready. Redirects from execute restart fetch at any time.
//
// state | meaning
// FETCH | reading byte k (0..3) at PC+k into lane k
// VALID | assembled word presented, waiting for Inst_Ready
module inst_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  inst_fetch_sequencer_if.master        bus,
  output logic                          Misaligned,
  output logic [CNT_W-1:0]              Retired_Count
);

  localparam logic [0:0] S_FETCH = FETCH;
  localparam logic [0:0] S_VALID = VALID;
  localparam logic [1:0] LAST_K  = 2'(INST_BYTES - 1);

  logic [0:0]      state;
  logic [1:0]      k;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic            inst_valid;
  logic [XLEN-1:0] inst_pc;
  logic            handshake;

  // Memory read port and decode outputs are direct views of the state.
  assign bus.Mem_Rd_En   = (state == S_FETCH);
  assign bus.Mem_Addr    = pc + XLEN'(k);
  assign bus.Instruction = instr;
  assign bus.Inst_Valid  = inst_valid;
  assign bus.Inst_PC     = inst_pc;

  assign handshake = (state == S_VALID) && inst_valid && bus.Inst_Ready;

  // Fetch FSM, byte assembler, retired counter and misalignment flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FETCH;
      k             <= 2'd0;
      pc            <= RESET_PC;
      instr         <= 32'h0;
      inst_valid    <= 1'b0;
      inst_pc       <= RESET_PC;
      Misaligned    <= 1'b0;
      Retired_Count <= '0;
    end else begin
      Misaligned <= bus.Redirect && (|bus.Redirect_PC[1:0]);

      // A handshake coincident with a redirect still retires the instruction.
      if (handshake) begin
        Retired_Count <= Retired_Count + CNT_W'(1);
      end

      if (bus.Redirect) begin
        // Partial bytes are dropped: k restarts and lanes get overwritten.
        pc         <= {bus.Redirect_PC[XLEN-1:2], 2'b00};
        k          <= 2'd0;
        state      <= S_FETCH;
        inst_valid <= 1'b0;
      end else begin
        case (state)
          S_FETCH: begin
            instr <= le_lane_write(instr, k, bus.Mem_Byte);
            k     <= k + 2'd1;
            if (k == LAST_K) begin
              state      <= S_VALID;
              inst_valid <= 1'b1;
              inst_pc    <= pc;
            end
          end
          S_VALID: begin
            if (bus.Inst_Ready) begin
              inst_valid <= 1'b0;
              pc         <= pc + XLEN'(PC_STEP);
              k          <= 2'd0;
              state      <= S_FETCH;
            end
          end
          default: begin
            state <= S_FETCH;
            k     <= 2'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Directed bench for inst_fetch_sequencer with a scoreboard of expected
// (instruction, PC) pairs checked on every decode handshake.
module tb_inst_fetch_sequencer;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic [31:0]     ins;
    logic [XLEN-1:0] pc;
  } exp_t;

  localparam logic [31:0] W0 = 32'h02853483;
  localparam logic [31:0] W1 = 32'h009A84B3;
  localparam logic [31:0] W2 = 32'h00148493;
  localparam logic [31:0] W3 = 32'h02953423;

  logic             clk;
  logic             reset;
  logic             misaligned;
  logic [CNT_W-1:0] retired_count;
  logic [7:0]       mem [16];

  int   checks;
  int   errors;
  exp_t sb[$];

  inst_fetch_sequencer_if #(.XLEN(XLEN)) bus ();

  inst_fetch_sequencer #(
    .XLEN    (XLEN),
    .RESET_PC(64'h0),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .Misaligned   (misaligned),
    .Retired_Count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: combinational read, zero outside the 16 loaded bytes.
  always_comb begin
    bus.Mem_Byte = 8'h00;
    if (bus.Mem_Addr < 64'd16) bus.Mem_Byte = mem[bus.Mem_Addr[3:0]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.Redirect    = 1'b0;
    bus.Redirect_PC = '0;
    bus.Inst_Ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !bus.Inst_Valid; i++) tick();
    chk(name, 64'(bus.Inst_Valid), 64'd1);
  endtask

  task automatic push(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    exp_t e;
    e.ins = ins;
    e.pc  = pc;
    sb.push_back(e);
  endtask

  // Monitor: every handshake must match the oldest expected instruction.
  always @(negedge clk) begin
    if (!reset && bus.Inst_Valid && bus.Inst_Ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_handshake_pc", bus.Inst_PC, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instruction", 64'(bus.Instruction), 64'(e.ins));
        chk("sb_inst_pc", bus.Inst_PC, e.pc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words [4];
    checks = 0;
    errors = 0;
    words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
    for (int w = 0; w < 4; w++)
      for (int b = 0; b < 4; b++)
        mem[w*4 + b] = words[w][b*8 +: 8];

    reset           = 1'b1;
    bus.Redirect    = 1'b0;
    bus.Redirect_PC = '0;
    bus.Inst_Ready  = 1'b1;
    #12;
    chk("rst_valid", 64'(bus.Inst_Valid), 64'd0);
    chk("rst_addr", bus.Mem_Addr, 64'd0);
    chk("rst_rd_en", 64'(bus.Mem_Rd_En), 64'd1);
    chk("rst_instr", 64'(bus.Instruction), 64'd0);
    chk("rst_pc", bus.Inst_PC, 64'd0);
    chk("rst_retired", 64'(retired_count), 64'd0);
    chk("rst_misaligned", 64'(misaligned), 64'd0);

    // 1: free-running fetch with Ready high
    push(W0, 0); push(W1, 4); push(W2, 8); push(W3, 12);
    @(negedge clk);
    reset = 1'b0;
    chk("t1_addr0", bus.Mem_Addr, 64'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t1_addr_step", bus.Mem_Addr, 64'(k));
    end
    tick();
    chk("t1_valid_edge4", 64'(bus.Inst_Valid), 64'd1);
    chk("t1_instr0", 64'(bus.Instruction), 64'(W0));
    chk("t1_pc0", bus.Inst_PC, 64'd0);
    repeat (5) tick();
    chk("t1_valid1", 64'(bus.Inst_Valid), 64'd1);
    chk("t1_instr1", 64'(bus.Instruction), 64'(W1));
    chk("t1_pc1", bus.Inst_PC, 64'd4);
    repeat (11) tick();
    bus.Inst_Ready = 1'b0;
    chk("t1_retired4", 64'(retired_count), 64'd4);

    // 2: stall then single-cycle Ready
    do_reset();
    wait_valid("t2_valid");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_hold_instr", 64'(bus.Instruction), 64'(W0));
      chk("t2_hold_pc", bus.Inst_PC, 64'd0);
      chk("t2_hold_rd_en", 64'(bus.Mem_Rd_En), 64'd0);
    end
    push(W0, 0);
    bus.Inst_Ready = 1'b1;
    tick();
    bus.Inst_Ready = 1'b0;
    chk("t2_retired", 64'(retired_count), 64'd1);
    chk("t2_addr4", bus.Mem_Addr, 64'd4);
    chk("t2_valid_low", 64'(bus.Inst_Valid), 64'd0);

    // 3: redirect to 12 while fetching byte 2 of the word at 4
    do_reset();
    push(W0, 0);
    push(W3, 12);
    bus.Inst_Ready = 1'b1;
    repeat (7) tick();
    chk("t3_addr_k2", bus.Mem_Addr, 64'd6);
    bus.Redirect    = 1'b1;
    bus.Redirect_PC = 64'd12;
    tick();
    bus.Redirect = 1'b0;
    chk("t3_addr12", bus.Mem_Addr, 64'd12);
    chk("t3_aligned", 64'(misaligned), 64'd0);
    wait_valid("t3_valid");
    chk("t3_instr", 64'(bus.Instruction), 64'(W3));
    chk("t3_pc", bus.Inst_PC, 64'd12);
    tick();
    bus.Inst_Ready = 1'b0;

    // 4: misaligned redirect to 0x9
    do_reset();
    repeat (2) tick();
    bus.Redirect    = 1'b1;
    bus.Redirect_PC = 64'h9;
    tick();
    bus.Redirect = 1'b0;
    push(W2, 8);
    chk("t4_misaligned_hi", 64'(misaligned), 64'd1);
    chk("t4_addr8", bus.Mem_Addr, 64'd8);
    tick();
    chk("t4_misaligned_lo", 64'(misaligned), 64'd0);
    wait_valid("t4_valid");
    chk("t4_instr", 64'(bus.Instruction), 64'(W2));
    bus.Inst_Ready = 1'b1;
    tick();
    bus.Inst_Ready = 1'b0;

    // 5: redirect coincident with handshake at PC 0
    do_reset();
    repeat (4) tick();
    push(W0, 0);
    push(W3, 12);
    bus.Inst_Ready  = 1'b1;
    bus.Redirect    = 1'b1;
    bus.Redirect_PC = 64'd12;
    tick();
    bus.Redirect   = 1'b0;
    bus.Inst_Ready = 1'b0;
    chk("t5_retired", 64'(retired_count), 64'd1);
    chk("t5_valid_low", 64'(bus.Inst_Valid), 64'd0);
    chk("t5_addr12", bus.Mem_Addr, 64'd12);
    wait_valid("t5_valid");
    chk("t5_pc_target", bus.Inst_PC, 64'd12);
    bus.Inst_Ready = 1'b1;
    tick();
    bus.Inst_Ready = 1'b0;

    // 6: asynchronous reset mid-fetch
    do_reset();
    push(W0, 0);
    bus.Inst_Ready = 1'b1;
    repeat (6) tick();
    bus.Inst_Ready = 1'b0;
    chk("t6_pre_retired", 64'(retired_count), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 64'(bus.Inst_Valid), 64'd0);
    chk("t6_async_addr", bus.Mem_Addr, 64'd0);
    chk("t6_async_retired", 64'(retired_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    push(W0, 0);
    wait_valid("t6_valid");
    chk("t6_instr", 64'(bus.Instruction), 64'(W0));
    bus.Inst_Ready = 1'b1;
    tick();
    bus.Inst_Ready = 1'b0;
    chk("t6_retired", 64'(retired_count), 64'd1);

    // 7: address wrap at the top of the address space
    do_reset();
    bus.Redirect    = 1'b1;
    bus.Redirect_PC = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    bus.Redirect = 1'b0;
    push(32'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("t7_misaligned", 64'(misaligned), 64'd1);
    chk("t7_addr_fc", bus.Mem_Addr, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("t7_addr_step", bus.Mem_Addr, 64'hFFFF_FFFF_FFFF_FFFC + 64'(k));
    end
    tick();
    chk("t7_valid", 64'(bus.Inst_Valid), 64'd1);
    bus.Inst_Ready = 1'b1;
    tick();
    bus.Inst_Ready = 1'b0;
    chk("t7_addr_wrap", bus.Mem_Addr, 64'd0);
    chk("t7_retired", 64'(retired_count), 64'd1);

    repeat (2) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
